// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit
// PC_COMPRESSED_EN narrows the misalignment mask to bit0 for 16-bit instructions
package pc_pkg;
    typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_e;
    localparam int STEP_WORD = 4;
    localparam int STEP_HALF = 2;
`ifdef PC_COMPRESSED_EN
    localparam logic [1:0] MISALIGN_MASK = 2'b01;
`else
    localparam logic [1:0] MISALIGN_MASK = 2'b11;
`endif
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: prioritised next-PC mux, sequential step and target misalignment check
// PC_COMPRESSED_EN selects a 2-byte step when instr_len2 is set
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            instr_len2,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            retire,
    output logic            misalign
);
    import pc_pkg::*;
    logic [XLEN-1:0] trap_base;
`ifdef PC_COMPRESSED_EN
    assign pc_plus = pc + XLEN'(instr_len2 ? STEP_HALF : STEP_WORD);
`else
    logic unused_len2;
    assign unused_len2 = instr_len2;
    assign pc_plus = pc + XLEN'(STEP_WORD);
`endif
    assign trap_base = trap_vector & ~XLEN'(3);
    // a trap outranks the branch, so a bad target is only flagged when no trap is pending
    assign misalign = !trap_req && br_taken && |(br_target[1:0] & MISALIGN_MASK);
    assign retire = !trap_req && !misalign;
    assign next_pc = (trap_req || misalign) ? trap_base : br_taken ? br_target : pc_plus;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with boot/run/halt FSM, stall hold, redirects and retire counter
// PC_COMPRESSED_EN enables 16-bit instruction steps and bit0-only misalignment
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             instr_len2,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus_out,
    output logic             fetch_valid,
    output logic             misaligned_exc,
    output logic [XLEN-1:0]  bad_addr,
    output logic [XLEN-1:0]  epc_out,
    output logic [CNT_W-1:0] instret
);
    import pc_pkg::*;
    pc_state_e       state;
    logic [XLEN-1:0] next_pc;
    logic            retire, misalign, run;

    pc_next_sel #(.XLEN(XLEN)) u_sel (
        .pc          (pc_out),
        .instr_len2  (instr_len2),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap_req    (trap_req),
        .trap_vector (trap_vector),
        .next_pc     (next_pc),
        .pc_plus     (pc_plus_out),
        .retire      (retire),
        .misalign    (misalign)
    );

    assign run = state == PC_RUN && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= PC_BOOT;
            pc_out         <= RESET_VECTOR;
            fetch_valid    <= 1'b0;
            misaligned_exc <= 1'b0;
            bad_addr       <= '0;
            epc_out        <= '0;
            instret        <= '0;
        end else begin
            misaligned_exc <= run && misalign;
            if (run) begin
                pc_out <= next_pc;
                if (misalign) bad_addr <= br_target;
                if (!retire) epc_out <= pc_out;
                if (retire) instret <= instret + CNT_W'(1);
                // halt is honoured only when the instruction actually retires
                if (retire && halt_req) begin
                    state       <= PC_HALT;
                    fetch_valid <= 1'b0;
                end
            end
            if (state == PC_BOOT || (state == PC_HALT && resume_req)) begin
                state       <= PC_RUN;
                fetch_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (default build, PC_COMPRESSED_EN undefined)
module tb_pc_unit;
    logic clk = 0, rst = 1, stall = 0, instr_len2 = 0, br_taken = 0;
    logic trap_req = 0, halt_req = 0, resume_req = 0;
    logic [31:0] br_target = 0, trap_vector = 0;
    logic [31:0] pc_out, pc_plus_out, bad_addr, epc_out;
    logic        fetch_valid, misaligned_exc;
    logic [63:0] instret;
    logic [31:0] w_pc, w_plus, w_bad, w_epc;
    logic        w_fv, w_exc;
    logic [1:0]  w_cnt;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .instr_len2(instr_len2),
        .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req),
        .trap_vector(trap_vector), .halt_req(halt_req), .resume_req(resume_req),
        .pc_out(pc_out), .pc_plus_out(pc_plus_out), .fetch_valid(fetch_valid),
        .misaligned_exc(misaligned_exc), .bad_addr(bad_addr), .epc_out(epc_out),
        .instret(instret)
    );

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .instr_len2(1'b0),
        .br_taken(1'b0), .br_target(32'h0), .trap_req(1'b0),
        .trap_vector(32'h0), .halt_req(1'b0), .resume_req(1'b0),
        .pc_out(w_pc), .pc_plus_out(w_plus), .fetch_valid(w_fv),
        .misaligned_exc(w_exc), .bad_addr(w_bad), .epc_out(w_epc),
        .instret(w_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, plus, bad, epc, wpc;
        logic [63:0] cnt;
        logic        fv, exc, wchk;
        logic [1:0]  wcnt;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0, errs = 0;
    logic [31:0] m_pc, m_bad, m_epc;
    logic [63:0] m_cnt;
    logic        m_fv, m_exc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic wchk, input logic [31:0] wpc, input logic [1:0] wcnt);
        exp_t e;
        q.push_back('{pc: m_pc, plus: m_pc + 32'd4, bad: m_bad, epc: m_epc, wpc: wpc,
                      cnt: m_cnt, fv: m_fv, exc: m_exc, wchk: wchk, wcnt: wcnt});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".pc"}, 64'(pc_out), 64'(e.pc));
        chk({tag, ".plus"}, 64'(pc_plus_out), 64'(e.plus));
        chk({tag, ".fv"}, 64'(fetch_valid), 64'(e.fv));
        chk({tag, ".exc"}, 64'(misaligned_exc), 64'(e.exc));
        chk({tag, ".bad"}, 64'(bad_addr), 64'(e.bad));
        chk({tag, ".epc"}, 64'(epc_out), 64'(e.epc));
        chk({tag, ".instret"}, instret, e.cnt);
        if (e.wchk) begin
            chk({tag, ".wrap_pc"}, 64'(w_pc), 64'(e.wpc));
            chk({tag, ".wrap_cnt"}, 64'(w_cnt), 64'(e.wcnt));
        end
    endtask

    initial begin
        m_pc = 32'h1000; m_cnt = 0; m_fv = 0; m_exc = 0; m_bad = 0; m_epc = 0;
        cyc("reset", 1, 32'hFFFF_FFF8, 0);
        rst = 0; m_fv = 1;
        cyc("boot", 1, 32'hFFFF_FFF8, 0);
        m_pc = 32'h1004; m_cnt = 1;
        cyc("seq1", 1, 32'hFFFF_FFFC, 1);
        m_pc = 32'h1008; m_cnt = 2;
        cyc("seq2", 1, 32'h0, 2);
        stall = 1; br_taken = 1; br_target = 32'h2000;
        cyc("stall0", 1, 32'h4, 3);
        cyc("stall1", 1, 32'h8, 0);
        cyc("stall2", 0, 32'h0, 0);
        stall = 0; m_pc = 32'h2000; m_cnt = 3;
        cyc("branch", 0, 32'h0, 0);
        br_taken = 0; m_pc = 32'h2004; m_cnt = 4;
        cyc("seq3", 0, 32'h0, 0);
        trap_vector = 32'h100; br_taken = 1; br_target = 32'h2002;
        m_exc = 1; m_bad = 32'h2002; m_epc = 32'h2004; m_pc = 32'h100;
        cyc("misalign", 0, 32'h0, 0);
        br_taken = 0; m_exc = 0; m_pc = 32'h104; m_cnt = 5;
        cyc("after_mis", 0, 32'h0, 0);
        br_taken = 1; br_target = 32'h3000; m_pc = 32'h3000; m_cnt = 6;
        cyc("br3000", 0, 32'h0, 0);
        trap_req = 1; halt_req = 1; trap_vector = 32'h103; m_pc = 32'h100; m_epc = 32'h3000;
        cyc("trap_combo", 0, 32'h0, 0);
        trap_req = 0; br_taken = 0; m_pc = 32'h104; m_cnt = 7; m_fv = 0;
        cyc("halt", 0, 32'h0, 0);
        halt_req = 0; br_taken = 1; br_target = 32'h5000; trap_req = 1;
        cyc("halted", 0, 32'h0, 0);
        br_taken = 0; trap_req = 0; resume_req = 1; m_fv = 1;
        cyc("resume", 0, 32'h0, 0);
        resume_req = 0; m_pc = 32'h108; m_cnt = 8;
        cyc("run_again", 0, 32'h0, 0);
        stall = 1; rst = 1; m_pc = 32'h1000; m_cnt = 0; m_fv = 0; m_bad = 0; m_epc = 0;
        cyc("rst_mid_stall", 1, 32'hFFFF_FFF8, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
